// File: rtl/ssd_pkg.sv
// Shared segment encodings and sizing helpers for the seven-segment scan driver.
package ssd_pkg;

    // abcdefg, active-low
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

    // Internal BCD digits: enough for the whole binary range, and at least one past the display.
    function automatic int bcd_digits(input int bin_w, input int num_digits);
        int need;
        need = (bin_w + 2) / 3;
        return (need > num_digits + 1) ? need : num_digits + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock, BIN_WIDTH clocks per result.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BIN_WIDTH  = 16
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS+3:0] bcd
);

    localparam int ND_INT = bcd_digits(BIN_WIDTH, NUM_DIGITS);
    localparam int BCD_W  = 4 * ND_INT;
    localparam int CNT_W  = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     adj, bcd_step;
    logic                 last;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < ND_INT; k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end
        end
        bcd_step = (adj << 1) | BCD_W'(bin_q[BIN_WIDTH-1]);
    end

    assign last = busy_q && (cnt_q == CNT_W'(BIN_WIDTH - 1));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        if (busy_q) begin
            bin_d = bin_q << 1;
            bcd_d = bcd_step;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            bin_d  = bin;
            bcd_d  = '0;
        end
    end

    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge ClkPort) begin
        bin_q <= bin_d;
        bcd_q <= bcd_d;
    end

    assign busy = busy_q;
    assign done = last;
    // The final step's result is presented combinationally so the display can latch it on the edge busy falls.
    // Guard nibble flags any nonzero digit beyond the display width.
    assign bcd  = {3'b000, |bcd_step[BCD_W-1:4*NUM_DIGITS], bcd_step[4*NUM_DIGITS-1:0]};

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment driver: hex or decimal display with blanking, per-digit enables and overflow dash.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int BIN_WIDTH    = 16,
    parameter int DWELL_CYCLES = 262144
) (
    input  logic                  ClkPort,
    input  logic                  Reset,
    input  logic [BIN_WIDTH-1:0]  value_in,
    input  logic                  load,
    input  logic                  mode_dec,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            cathodes
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int DISP_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      dwell_q, dwell_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic                  dec_q, dec_d;
    logic                  blz_q, blz_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            cath_q, cath_d;

    logic                  accept, conv_busy, conv_done;
    logic [DISP_W+3:0]     conv_bcd;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [3:0]            nib;
    logic                  blanked, dark;

    // A load arriving while a conversion is running, including its last cycle, is dropped.
    assign accept = load && !conv_busy;

    bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_WIDTH  (BIN_WIDTH)
    ) u_bin2bcd (
        .ClkPort (ClkPort),
        .Reset   (Reset),
        .start   (accept && mode_dec),
        .bin     (value_in),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    always_comb begin
        dwell_d = dwell_q + 1'b1;
        idx_d   = idx_q;
        if (dwell_q == CNT_W'(DWELL_CYCLES - 1)) begin
            dwell_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        disp_d = disp_q;
        ovf_d  = ovf_q;
        dec_d  = dec_q;
        blz_d  = blz_q;
        if (accept) begin
            dec_d = mode_dec;
            blz_d = blank_lz;
            if (!mode_dec) begin
                disp_d = DISP_W'(value_in);
                ovf_d  = 1'b0;
            end
        end
        if (conv_done && dec_q) begin
            disp_d = conv_bcd[DISP_W-1:0];
            ovf_d  = |conv_bcd[DISP_W+3:DISP_W];
        end
    end

    // upper_zero[i]: digits i..NUM_DIGITS-1 are all zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (disp_q[DISP_W-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (disp_q[4*i +: 4] == 4'h0);
        end
    end

    always_comb begin
        nib     = disp_q[4*idx_q +: 4];
        blanked = blz_q && (idx_q != '0) && upper_zero[idx_q];
        dark    = !digit_en[idx_q] || (blanked && !ovf_q);
        an_d    = dark ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        cath_d  = dark ? SEG_OFF : {(ovf_q ? SEG_DASH : seg_of(nib)), ~dp_mask[idx_q]};
    end

    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            dwell_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            dec_q   <= 1'b0;
            blz_q   <= 1'b0;
            an_q    <= '1;
            cath_q  <= SEG_OFF;
        end else begin
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            dec_q   <= dec_d;
            blz_q   <= blz_d;
            an_q    <= an_d;
            cath_q  <= cath_d;
        end
    end

    assign busy     = conv_busy;
    assign an       = an_q;
    assign cathodes = cath_q;

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
Parametrised seven-segment scan driver. It replaces the fixed 4-digit hex multiplexer and decoder in the top level. It generalises to NUM_DIGITS digits and adds:
- a decimal mode, using a sequential binary-to-BCD converter;
- leading-zero blanking;
- per-digit enables and decimal-point masks;
- overflow indication.

It sits between game logic (score, timers) and the board's An*/C* pins, and is clocked by ClkPort.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8).
BIN_WIDTH, 16, width of the binary input value.
DWELL_CYCLES, 262144, clock cycles each digit stays lit (2.62 ms at 100 MHz).

Ports:
ClkPort  in  1  system clock, 100 MHz.
Reset  in  1  synchronous, active-high reset.
value_in  in  BIN_WIDTH  value to display, captured on load.
load  in  1  single-cycle request to capture value_in, mode_dec, blank_lz.
mode_dec  in  1  0 = hex digits, 1 = decimal (BCD) digits.
blank_lz  in  1  1 = suppress leading zeros.
dp_mask  in  NUM_DIGITS  1 = light the decimal point of digit i (live, not captured).
digit_en  in  NUM_DIGITS  0 = force digit i dark (live).
busy  out  1  high while a decimal conversion is in progress.
an  out  NUM_DIGITS  anodes, active-low, one-hot-low or all high.
cathodes  out  8  {a,b,c,d,e,f,g,dp}, active-low.

Behaviour:
Clocking and reset
- One clock, ClkPort. Reset is synchronous and active-high and wins over every other input.

Reset values
- an = all 1; cathodes = 8'hFF; busy = 0.
- Display register = 0; dwell counter = 0; scan index = 0; captured mode_dec = 0; captured blank_lz = 0.

Scan
- Dwell counter counts 0..DWELL_CYCLES-1.
- On wrap, the index advances; index NUM_DIGITS-1 wraps to 0.
- an and cathodes are registered and reflect the current index one cycle later.

Digit dark conditions
- Digit i is dark (an[i]=1, cathodes=8'hFF) if digit_en[i]=0, or if it is blanked.
- Blanked means: captured blank_lz=1, i>0, and digits i..NUM_DIGITS-1 are all zero.
- Digit 0 is never blanked.

Lit digits
- The active anode is low.
- Segments come from the 16-entry table (0 = 8'b0000001x ... F = 8'b0111000x, abcdefg).
- dp = ~dp_mask[i].

Load in hex mode (mode_dec=0)
- Display register takes value_in nibbles on the cycle after load, zero-extended or truncated to NUM_DIGITS nibbles.
- busy stays 0.

Load in decimal mode (mode_dec=1)
- Sub-module starts on the cycle after load, and busy rises that same cycle.
- Conversion runs exactly BIN_WIDTH shift-add-3 cycles.
- On the final cycle the display register is updated atomically and busy falls.
- The old value stays displayed throughout the conversion.

Overflow
- Applies when the BCD result has a nonzero digit at position >= NUM_DIGITS.
- All enabled digits then show dash (8'b1111110, plus dp from dp_mask); blanking is ignored.

Load while busy
- Ignored; no queueing.
- A load on the same cycle busy falls is also ignored.

Reset mid-conversion
- Aborts the conversion; the display returns to 0.

mode_dec and blank_lz
- Sampled only on an accepted load.

Decomposition:
Package ssd_pkg:
- SEG_HEX[0:15] segment constants.
- SEG_DASH and SEG_OFF constants.
- Function seg_of(nibble).

Sub-module bin2bcd_seq (double-dabble):
- Ports: ClkPort, Reset, start, bin, busy, done, bcd[4*NUM_DIGITS+3:0] (one guard digit for overflow detect).

Top holds the dwell counter, index, display register, blanking logic and output registers.

Test Plan:
Use DWELL_CYCLES=4, NUM_DIGITS=4, BIN_WIDTH=16 in the bench.
1. Reset, no load -> an cycles 1110 only (digits 1-3 dark via lz? no: blank_lz=0) -> an sequence 1110,1101,1011,0111, every 4 cycles, cathodes 8'b00000011 each.
2. load value_in=16'h3A7F, mode_dec=0 -> cathodes for F,7,A,3 on digits 0..3 from cycle 2 after load; busy never high.
3. load 16'd1234, mode_dec=1 -> busy high exactly 16 cycles; then digits show 4,3,2,1; a second load during busy is ignored.
4. load 16'd42, mode_dec=1, blank_lz=1 -> digits 2,3 an stay 1; digit 0 = "2", digit 1 = "4".
5. load 16'd12345, mode_dec=1 -> all four digits show 8'b11111101 (dash); dp_mask=4'b0001 -> digit 0 shows 8'b11111100.
6. Reset asserted at busy cycle 8 -> next cycle busy=0, an=1111, cathodes=8'hFF; afterwards digit 0 shows "0".
